// File: rtl/bus_demux_pkg.sv
// Shared definitions for the bus demultiplexer router.
//
// Contents:
//   slot_st_t  - occupancy state of a one-entry output holding register
//   STAT_W     - width of each statistics counter
//   sel_width  - width of a select field able to address n outputs
package bus_demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_st_t;

  localparam int STAT_W = 16;

  // Never narrower than one bit so a select port always exists.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_demux_slot.sv
// One-entry register slice used as the holding register of a router output.
//
// Ports:
//   clk         - rising-edge clock
//   reset_n     - asynchronous active-low reset, empties the slot
//   load        - write load_data into the slot this cycle (only when can_load)
//   load_data   - word to capture
//   drain_ready - downstream consumer accepts the held word
//   valid       - slot is FULL
//   data        - held word; keeps its last value while EMPTY
//   can_load    - slot can accept a word this cycle (empty, or draining now)
module bus_demux_slot
  import bus_demux_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_load
);

  slot_st_t         state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign valid    = (state_q == SLOT_FULL);
  assign data     = data_q;
  // A full slot that is being drained this cycle can be refilled in the same
  // cycle, which is what gives one word per cycle per port.
  assign can_load = (state_q == SLOT_EMPTY) || drain_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if ((state_q == SLOT_FULL) && drain_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/bus_demux_router.sv
// Registered 1-to-NUM_OUT bus demultiplexer with valid/ready handshake.
// Each output owns a one-entry holding register, so a stalled consumer only
// blocks words addressed to its own port. Words whose select is out of range
// are accepted, discarded and reported with a one-cycle drop_pulse.
//
// Ports:
//   clk, reset_n      - clock and asynchronous active-low reset
//   in_data/in_sel    - input word and destination port index
//   in_valid/in_ready - input handshake (in_ready never depends on in_valid)
//   out_data          - packed outputs, port k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready - per-port output handshake
//   drop_pulse        - one cycle after an out-of-range word was discarded
//   stat_count        - (BUS_DEMUX_ROUTER_STATS_EN) 16-bit saturating
//                       transfer counter per port, packed like out_data
//   stat_drops        - (BUS_DEMUX_ROUTER_STATS_EN) saturating drop count
//
// Build option: define BUS_DEMUX_ROUTER_STATS_EN to add the statistics ports.
module bus_demux_router
  import bus_demux_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NUM_OUT = 2,
  localparam int SEL_W  = sel_width(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     drop_pulse
`ifdef BUS_DEMUX_ROUTER_STATS_EN
  ,
  output logic [NUM_OUT*STAT_W-1:0] stat_count,
  output logic [STAT_W-1:0]         stat_drops
`endif
);

  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] can_load;
  logic               in_range;
  logic               drop_d, drop_q;

  // Select decode: an unmatched select leaves in_ready at 1 so the word is
  // swallowed and turned into a drop instead of stalling the producer.
  always_comb begin
    in_range = 1'b0;
    in_ready = 1'b1;
    load     = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (in_sel == SEL_W'(k)) begin
        in_range = 1'b1;
        in_ready = can_load[k];
        load[k]  = in_valid && can_load[k];
      end
    end
    drop_d = in_valid && !in_range;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_pulse = drop_q;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    bus_demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load[g]),
      .load_data  (in_data),
      .drain_ready(out_ready[g]),
      .valid      (out_valid[g]),
      .data       (out_data[g*WIDTH +: WIDTH]),
      .can_load   (can_load[g])
    );
  end

`ifdef BUS_DEMUX_ROUTER_STATS_EN
  logic [NUM_OUT*STAT_W-1:0] stat_count_q, stat_count_d;
  logic [STAT_W-1:0]         stat_drops_q, stat_drops_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_count_d = stat_count_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (out_valid[k] && out_ready[k] &&
          (stat_count_q[k*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
        stat_count_d[k*STAT_W +: STAT_W] = stat_count_q[k*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
    stat_drops_d = stat_drops_q;
    if (drop_d && (stat_drops_q != {STAT_W{1'b1}})) begin
      stat_drops_d = stat_drops_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_count_q <= '0;
      stat_drops_q <= '0;
    end else begin
      stat_count_q <= stat_count_d;
      stat_drops_q <= stat_drops_d;
    end
  end

  assign stat_count = stat_count_q;
  assign stat_drops = stat_drops_q;
`endif

endmodule

// File: tb/tb_bus_demux_router.sv
// Self-checking bench for bus_demux_router (WIDTH=16, NUM_OUT=3 so that
// select value 3 is out of range). A transaction-level model tracks, per port,
// whether a word is waiting and which word it is.
module tb_bus_demux_router;

  localparam int W = 16;
  localparam int N = 3;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic          drop_pulse;
`ifdef BUS_DEMUX_ROUTER_STATS_EN
  logic [N*16-1:0] stat_count;
  logic [15:0]     stat_drops;
`endif

  bus_demux_router #(
    .WIDTH  (W),
    .NUM_OUT(N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_pulse(drop_pulse)
`ifdef BUS_DEMUX_ROUTER_STATS_EN
    ,
    .stat_count(stat_count),
    .stat_drops(stat_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Transaction model: a port either holds one pending word or nothing.
  bit         m_full [N];
  logic [W-1:0] m_word [N];
  int         m_cnt  [N];
  int         m_drops;
  bit         m_drop;
  logic       obs_ready;
  logic       exp_ready;

  function automatic logic [N-1:0] m_valid_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic [N*W-1:0] m_data_vec();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = m_word[k];
    return d;
  endfunction

  function automatic logic [N*16-1:0] m_cnt_vec();
    logic [N*16-1:0] c;
    for (int k = 0; k < N; k++) c[k*16 +: 16] = 16'(m_cnt[k]);
    return c;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = '0;
      m_cnt[k]  = 0;
    end
    m_drops = 0;
    m_drop  = 1'b0;
  endtask

  // Drives one clock cycle starting just after a rising edge, samples
  // in_ready mid-cycle and advances the model across the next edge.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [N-1:0] r);
    int  si;
    bit  acc;
    si        = int'(s);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #2;
    obs_ready = in_ready;
    exp_ready = (si >= N) ? 1'b1 : (!m_full[si] || r[si]);
    acc       = v && exp_ready;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (m_full[k] && r[k]) begin
        m_full[k] = 1'b0;
        if (m_cnt[k] < 65535) m_cnt[k]++;
      end
    end
    m_drop = acc && (si >= N);
    if (m_drop && m_drops < 65535) m_drops++;
    if (acc && si < N) begin
      m_full[si] = 1'b1;
      m_word[si] = d;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_compared++;
    if (out_valid !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valid: got %b expected %b", out_valid, 3'b000);
    end
    n_compared++;
    if (out_data !== 48'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got %h expected %h", out_data, 48'h0);
    end
    n_compared++;
    if (drop_pulse !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_drop: got %b expected 0", drop_pulse);
    end
    n_compared++;
    if (in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic_steer();
    cycle(1'b1, 2'd0, 16'hCA35, 3'b111);
    n_compared++;
    if (out_valid !== 3'b001) begin
      n_mismatched++;
      $display("[TB] FAIL steer_valid: got %b expected %b", out_valid, 3'b001);
    end
    n_compared++;
    if (out_data[15:0] !== 16'hCA35) begin
      n_mismatched++;
      $display("[TB] FAIL steer_data: got %h expected %h", out_data[15:0], 16'hCA35);
    end
    n_compared++;
    if (out_data[31:16] !== 16'h0000) begin
      n_mismatched++;
      $display("[TB] FAIL steer_port1_untouched: got %h expected %h", out_data[31:16], 16'h0);
    end
    cycle(1'b0, 2'd0, 16'h0000, 3'b111);
    n_compared++;
    if (out_valid !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL steer_drain: got %b expected %b", out_valid, 3'b000);
    end
  endtask

  task automatic test_back_pressure();
    cycle(1'b1, 2'd1, 16'hE6F2, 3'b101);
    n_compared++;
    if (obs_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL bp_first_ready: got %b expected 1", obs_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd1, 16'h35CA, 3'b101);
      n_compared++;
      if (obs_ready !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL bp_stalled_ready: got %b expected 0", obs_ready);
      end
      n_compared++;
      if (out_valid[1] !== 1'b1 || out_data[31:16] !== 16'hE6F2) begin
        n_mismatched++;
        $display("[TB] FAIL bp_hold: got v=%b d=%h expected v=1 d=%h",
                 out_valid[1], out_data[31:16], 16'hE6F2);
      end
    end
    cycle(1'b1, 2'd1, 16'h35CA, 3'b111);
    n_compared++;
    if (obs_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL bp_release_ready: got %b expected 1", obs_ready);
    end
    n_compared++;
    if (out_valid[1] !== 1'b1 || out_data[31:16] !== 16'h35CA) begin
      n_mismatched++;
      $display("[TB] FAIL bp_second_word: got v=%b d=%h expected v=1 d=%h",
               out_valid[1], out_data[31:16], 16'h35CA);
    end
    cycle(1'b0, 2'd0, 16'h0000, 3'b111);
  endtask

  task automatic test_independence();
    cycle(1'b1, 2'd1, 16'hAAAA, 3'b101);
    cycle(1'b1, 2'd0, 16'h1234, 3'b101);
    n_compared++;
    if (obs_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL indep_ready: got %b expected 1", obs_ready);
    end
    n_compared++;
    if (out_valid !== 3'b011 || out_data[15:0] !== 16'h1234 || out_data[31:16] !== 16'hAAAA) begin
      n_mismatched++;
      $display("[TB] FAIL indep_outputs: got v=%b d0=%h d1=%h expected v=011 d0=1234 d1=aaaa",
               out_valid, out_data[15:0], out_data[31:16]);
    end
    cycle(1'b0, 2'd0, 16'h0000, 3'b111);
  endtask

  task automatic test_throughput();
    logic [W-1:0] word;
    for (int i = 0; i < 8; i++) begin
      word = 16'h1000 + 16'(i * 16'h0111);
      cycle(1'b1, 2'd0, word, 3'b111);
      n_compared++;
      if (obs_ready !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL tput_ready[%0d]: got %b expected 1", i, obs_ready);
      end
      n_compared++;
      if (out_valid[0] !== 1'b1 || out_data[15:0] !== word) begin
        n_mismatched++;
        $display("[TB] FAIL tput_word[%0d]: got v=%b d=%h expected v=1 d=%h",
                 i, out_valid[0], out_data[15:0], word);
      end
    end
    cycle(1'b0, 2'd0, 16'h0000, 3'b111);
    n_compared++;
    if (out_valid !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL tput_empty: got %b expected %b", out_valid, 3'b000);
    end
  endtask

  task automatic test_drop();
    cycle(1'b1, 2'd1, 16'h7777, 3'b000);
    cycle(1'b1, 2'd3, 16'hBEEF, 3'b000);
    n_compared++;
    if (obs_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL drop_ready: got %b expected 1", obs_ready);
    end
    n_compared++;
    if (drop_pulse !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL drop_pulse: got %b expected 1", drop_pulse);
    end
    n_compared++;
    if (out_valid !== 3'b010 || out_data[31:16] !== 16'h7777) begin
      n_mismatched++;
      $display("[TB] FAIL drop_slots: got v=%b d1=%h expected v=010 d1=7777",
               out_valid, out_data[31:16]);
    end
`ifdef BUS_DEMUX_ROUTER_STATS_EN
    n_compared++;
    if (stat_drops !== 16'd1) begin
      n_mismatched++;
      $display("[TB] FAIL drop_stat: got %0d expected 1", stat_drops);
    end
`endif
    cycle(1'b0, 2'd3, 16'h0000, 3'b111);
    n_compared++;
    if (drop_pulse !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL drop_one_cycle: got %b expected 0", drop_pulse);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 2'd0, 16'h1111, 3'b000);
    cycle(1'b1, 2'd1, 16'h2222, 3'b000);
    n_compared++;
    if (out_valid !== 3'b011) begin
      n_mismatched++;
      $display("[TB] FAIL arst_prefill: got %b expected %b", out_valid, 3'b011);
    end
    in_valid = 1'b0;
    in_sel   = 2'd0;
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    n_compared++;
    if (out_valid !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL arst_immediate: got %b expected %b", out_valid, 3'b000);
    end
    n_compared++;
    if (in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL arst_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 2'd0, 16'h5A5A, 3'b111);
    n_compared++;
    if (out_valid !== 3'b001 || out_data[15:0] !== 16'h5A5A) begin
      n_mismatched++;
      $display("[TB] FAIL arst_resume: got v=%b d0=%h expected v=001 d0=5a5a",
               out_valid, out_data[15:0]);
    end
    cycle(1'b0, 2'd0, 16'h0000, 3'b111);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            3'($urandom_range(0, 7)));
      n_compared++;
      if (obs_ready !== exp_ready) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_in_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready);
      end
      n_compared++;
      if (out_valid !== m_valid_vec()) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, m_valid_vec());
      end
      n_compared++;
      if (out_data !== m_data_vec()) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", i, out_data, m_data_vec());
      end
      n_compared++;
      if (drop_pulse !== m_drop) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_drop[%0d]: got %b expected %b", i, drop_pulse, m_drop);
      end
`ifdef BUS_DEMUX_ROUTER_STATS_EN
      n_compared++;
      if (stat_count !== m_cnt_vec() || stat_drops !== 16'(m_drops)) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_stats[%0d]: got %h/%0d expected %h/%0d",
                 i, stat_count, stat_drops, m_cnt_vec(), m_drops);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic_steer();
    test_back_pressure();
    test_independence();
    test_throughput();
    test_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
